// File: rtl/iir_pkg.sv
// Shared widths, FSM states and result reduction for the iir1_mc filter.
// IIR_SAT_EN selects clamping instead of wrap in the reduction step.
package iir_pkg;

    localparam int DW_DEF = 8;
    localparam int CW_DEF = 4;
    localparam int OW_DEF = 17;
    localparam int CH_DEF = 4;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } iir_st_t;

    // acc carries ACC bits sign-extended to 64; result is OW bits, sign-extended.
    function automatic logic signed [63:0] iir_reduce(
        input logic signed [63:0] acc,
        input int                 ow,
        input logic               sat
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] wr;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        wr = (acc <<< (64 - ow)) >>> (64 - ow);
        if (sat && (acc > hi)) begin
            return hi;
        end else if (sat && (acc < lo)) begin
            return lo;
        end
        return wr;
    endfunction

endpackage

// File: rtl/iir_mac.sv
// Output stage: a*y_prev + bx, reduced to OW bits, registered on en.
// IIR_SAT_EN clamps the result and adds the out_sat flag.
module iir_mac
    import iir_pkg::*;
#(
    parameter int CW  = CW_DEF,
    parameter int OW  = OW_DEF,
    parameter int BW  = CW_DEF + DW_DEF,
    parameter int CHW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           in_v,
    input  logic [CHW-1:0] in_ch,
    input  logic [CW-1:0]  a,
    input  logic [OW-1:0]  y_prev,
    input  logic [BW-1:0]  bx,
    output logic [OW-1:0]  y_nxt,
    output logic           out_valid,
    output logic [CHW-1:0] out_ch,
    output logic [OW-1:0]  out_data
`ifdef IIR_SAT_EN
    ,
    output logic           out_sat
`endif
);

    localparam int ACC = CW + OW + 1;
`ifdef IIR_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic signed [CW+OW-1:0] ay;
    logic signed [ACC-1:0]   acc;
    logic signed [63:0]      acc64;
    logic signed [63:0]      red64;

    assign ay    = (CW+OW)'($signed(a)) * (CW+OW)'($signed(y_prev));
    assign acc   = ACC'(ay) + ACC'($signed(bx));
    assign acc64 = 64'(acc);
    assign red64 = iir_reduce(acc64, OW, SAT);
    assign y_nxt = red64[OW-1:0];

`ifdef IIR_SAT_EN
    logic sat_nxt;
    assign sat_nxt = (red64 != acc64);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sat <= 1'b0;
        end else if (en && in_v) begin
            out_sat <= sat_nxt;
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^red64[63:OW];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= in_v;
            if (in_v) begin
                out_ch   <= in_ch;
                out_data <= y_nxt;
            end
        end
    end

endmodule

// File: rtl/iir1_mc.sv
// Multi-channel time-multiplexed first-order IIR: y = a*y_prev + b*x.
// Build option IIR_SAT_EN: saturating reduction plus out_sat port.
module iir1_mc
    import iir_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int CW  = CW_DEF,
    parameter int OW  = OW_DEF,
    parameter int CH  = CH_DEF,
    parameter int CHW = $clog2(CH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [CW-1:0]  coef_a,
    input  logic [CW-1:0]  coef_b,
    input  logic           clr_all,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [CHW-1:0] in_ch,
    input  logic [DW-1:0]  in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [CHW-1:0] out_ch,
    output logic [OW-1:0]  out_data
`ifdef IIR_SAT_EN
    ,
    output logic           out_sat
`endif
);

    localparam int BW = CW + DW;

    iir_st_t        st_q, st_d;
    logic [CHW-1:0] clr_idx_q, clr_idx_d;
    logic [OW-1:0]  state_q [CH];

    logic           s1_v;
    logic [CHW-1:0] s1_ch;
    logic [CW-1:0]  s1_a;
    logic [CW-1:0]  s1_b;
    logic [DW-1:0]  s1_x;
    logic [OW-1:0]  s1_y;

    logic           advance;
    logic           accept;
    logic [BW-1:0]  bx;
    logic [OW-1:0]  y_nxt;
    logic [OW-1:0]  y_rd;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && (st_q == RUN);
    assign accept   = in_valid && in_ready;
    assign bx       = BW'($signed(s1_b)) * BW'($signed(s1_x));

    // S1 leaves on this same edge; take its result if it targets our channel.
    assign y_rd = (s1_v && (s1_ch == in_ch) && (st_q == RUN))
                ? y_nxt : state_q[in_ch];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v  <= 1'b0;
            s1_ch <= '0;
            s1_a  <= '0;
            s1_b  <= '0;
            s1_x  <= '0;
            s1_y  <= '0;
        end else if (advance) begin
            s1_v <= accept;
            if (accept) begin
                s1_ch <= in_ch;
                s1_a  <= coef_a;
                s1_b  <= coef_b;
                s1_x  <= in_data;
                s1_y  <= y_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= '0;
            end
        end else if (st_q == CLEAR) begin
            state_q[clr_idx_q] <= '0;
        end else if (advance && s1_v) begin
            state_q[s1_ch] <= y_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= RUN;
            clr_idx_q <= '0;
        end else begin
            st_q      <= st_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        st_d      = st_q;
        clr_idx_d = clr_idx_q;
        unique case (st_q)
            RUN: begin
                if (clr_all) begin
                    st_d      = CLEAR;
                    clr_idx_d = '0;
                end
            end
            CLEAR: begin
                if (clr_idx_q == CHW'(CH - 1)) begin
                    st_d = RUN;
                end else begin
                    clr_idx_d = clr_idx_q + CHW'(1);
                end
            end
            default: st_d = RUN;
        endcase
    end

    iir_mac #(
        .CW  (CW),
        .OW  (OW),
        .BW  (BW),
        .CHW (CHW)
    ) u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (advance),
        .in_v      (s1_v),
        .in_ch     (s1_ch),
        .a         (s1_a),
        .y_prev    (s1_y),
        .bx        (bx),
        .y_nxt     (y_nxt),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_data  (out_data)
`ifdef IIR_SAT_EN
        ,
        .out_sat   (out_sat)
`endif
    );

endmodule

// File: tb/tb_iir1_mc.sv
// Randomised and directed bench for iir1_mc against a serial model.
// Define IIR_SAT_EN to check the saturating build.
module tb_iir1_mc;

    localparam int DW  = 8;
    localparam int CW  = 4;
    localparam int OW  = 17;
    localparam int CH  = 4;
    localparam int CHW = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic signed [CW-1:0]  coef_a = '0;
    logic signed [CW-1:0]  coef_b = '0;
    logic                  clr_all = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [CHW-1:0]        in_ch = '0;
    logic signed [DW-1:0]  in_data = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [CHW-1:0]        out_ch;
    logic signed [OW-1:0]  out_data;
`ifdef IIR_SAT_EN
    logic                  out_sat;
`endif

    always #5 clk = ~clk;

    iir1_mc #(
        .DW (DW), .CW (CW), .OW (OW), .CH (CH), .CHW (CHW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .coef_a    (coef_a),
        .coef_b    (coef_b),
        .clr_all   (clr_all),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data)
`ifdef IIR_SAT_EN
        ,
        .out_sat   (out_sat)
`endif
    );

    typedef struct {
        int     ch;
        longint data;
        bit     sat;
    } exp_t;

    exp_t   q[$];
    longint obs[$];
    longint st[CH];
    int     n_chk = 0;
    int     n_fail = 0;
    int     cyc = 0;
    int     clr_cnt = 0;
    bit     held = 0;
    longint hd;
    longint hc;
    int     first_acc = -1;
    int     first_out = -1;
    bit     last_acc;
    bit     last_rdy;

    task automatic check(string tag, longint got, longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint model(int ch, longint a, longint b,
                                     longint x, output bit s);
        longint v, hi, lo, m;
        m  = longint'(1) << OW;
        hi = (longint'(1) << (OW - 1)) - 1;
        lo = -hi - 1;
        v  = a * st[ch] + b * x;
`ifdef IIR_SAT_EN
        s = (v > hi) || (v < lo);
        if (v > hi) v = hi;
        if (v < lo) v = lo;
`else
        s = 0;
        v = ((v % m) + m) % m;
        if (v > hi) v = v - m;
`endif
        st[ch] = v;
        return v;
    endfunction

    task automatic model_flush();
        q.delete();
        for (int i = 0; i < CH; i++) st[i] = 0;
        clr_cnt = 0;
        held    = 0;
    endtask

    task automatic step();
        exp_t e;
        bit   s;
        bit   exp_rdy;
        @(negedge clk);
        exp_rdy = (clr_cnt == 0) && (!out_valid || out_ready);
        check("in_ready", longint'(in_ready), longint'(exp_rdy));
        last_rdy = in_ready;
        if (held) begin
            check("hold_valid", longint'(out_valid), 1);
            check("hold_data", out_data, hd);
            check("hold_ch", longint'(out_ch), hc);
        end
        held = 0;
        if (out_valid && first_out < 0 && first_acc >= 0) first_out = cyc;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e = q.pop_front();
                check("out_ch", longint'(out_ch), e.ch);
                check("out_data", out_data, e.data);
`ifdef IIR_SAT_EN
                check("out_sat", longint'(out_sat), longint'(e.sat));
`endif
                obs.push_back(out_data);
            end
        end else if (out_valid) begin
            held = 1;
            hd   = out_data;
            hc   = out_ch;
        end
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            if (first_acc < 0) first_acc = cyc;
            e.ch   = in_ch;
            e.data = model(in_ch, coef_a, coef_b, in_data, s);
            e.sat  = s;
            q.push_back(e);
        end
        if (clr_cnt > 0) begin
            clr_cnt--;
        end else if (clr_all) begin
            clr_cnt = CH;
            for (int i = 0; i < CH; i++) st[i] = 0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(int ch, int x);
        int n = 0;
        in_valid = 1;
        in_ch    = CHW'(ch);
        in_data  = DW'(x);
        do begin
            step();
            n++;
        end while (!last_acc && n < 20);
        if (!last_acc) check("send_timeout", 0, 1);
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 0;
        clr_all   = 0;
        out_ready = 1;
        while ((q.size() > 0 || clr_cnt > 0) && n < 40) begin
            step();
            n++;
        end
        step();
        check("drain_empty", q.size(), 0);
    endtask

    task automatic do_clear();
        clr_all = 1;
        step();
        clr_all = 0;
        drain();
    endtask

    initial begin
        int i;
        int k;
        int n;
        int pat[2];
        pat[0] = 1;
        pat[1] = 2;
        model_flush();

        #12;
        check("rst_valid", longint'(out_valid), 0);
        check("rst_data", out_data, 0);
        check("rst_ch", longint'(out_ch), 0);
        check("rst_ready", longint'(in_ready), 1);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Test 1: a=-2, b=3, ch0 x=1,2,...
        coef_a = -2;
        coef_b = 3;
        obs.delete();
        first_acc = -1;
        first_out = -1;
        in_valid = 1;
        in_ch    = 0;
        for (int j = 0; j < 8; j++) begin
            in_data = DW'(pat[j % 2]);
            step();
        end
        drain();
        check("latency", first_out - first_acc, 2);
        check("t1_n", obs.size(), 8);
        for (int j = 0; j < 4; j++) begin
            check("t1_val", obs[j], (j % 2 == 0) ? 3 : 0);
        end

        // Test 2: interleaved ch0/ch1 then back-to-back ch0
        do_clear();
        obs.delete();
        in_valid = 1;
        for (int j = 0; j < 8; j++) begin
            in_ch   = CHW'(j % 2);
            in_data = DW'((j % 2) + 1);
            step();
        end
        in_ch   = 0;
        in_data = 1;
        repeat (4) step();
        drain();
        check("t2_a", obs[0], 3);
        check("t2_b", obs[1], 6);
        check("t2_c", obs[2], -3);
        check("t2_d", obs[3], -6);
        check("t2_e", obs[6], -15);
        check("t2_f", obs[7], -30);
        check("t2_g", obs[8], 33);

        // Test 3: growth to the OW limit on ch2
        obs.delete();
        in_valid = 1;
        in_ch    = 2;
        in_data  = 1;
        repeat (20) step();
        drain();
        check("t3_n16", obs[15], -65535);
`ifdef IIR_SAT_EN
        check("t3_n17", obs[16], 65535);
        check("t3_n18", obs[17], -65536);
        check("t3_n19", obs[18], 65535);
`else
        check("t3_n17", obs[16], 1);
        check("t3_n18", obs[17], 1);
`endif

        // Test 4: backpressure on ch3
        obs.delete();
        i = 0;
        k = 0;
        in_ch = 3;
        while (i < 10 && k < 40) begin
            out_ready = !(k >= 4 && k < 7);
            in_valid  = 1;
            in_data   = DW'(pat[i % 2]);
            step();
            if (last_acc) i++;
            k++;
        end
        drain();
        check("t4_n", obs.size(), 10);
        for (int j = 0; j < 10; j++) begin
            check("t4_val", obs[j], (j % 2 == 0) ? 3 : 0);
        end

        // Test 5: clear with two samples in flight
        in_valid = 1;
        in_ch    = 0;
        in_data  = 1;
        step();
        in_data = 2;
        step();
        in_valid = 0;
        clr_all  = 1;
        step();
        clr_all = 0;
        n = 0;
        k = 0;
        do begin
            step();
            if (!last_rdy) n++;
            k++;
        end while (!last_rdy && k < 12);
        check("clr_len", n, CH);
        drain();
        obs.delete();
        send(0, 1);
        drain();
        check("t5_y", obs[0], 3);

        // Test 6: asynchronous reset mid-stream
        in_valid = 1;
        in_ch    = 1;
        in_data  = 1;
        repeat (3) step();
        check("pre_rst_valid", longint'(out_valid), 1);
        rst_n = 0;
        #1;
        check("rst_async_valid", longint'(out_valid), 0);
        check("rst_async_data", out_data, 0);
        in_valid = 0;
        model_flush();
        @(posedge clk);
        #1;
        rst_n = 1;
        obs.delete();
        coef_a = -2;
        coef_b = 3;
        send(0, 2);
        drain();
        check("t6_n", obs.size(), 1);
        check("t6_y", obs[0], 6);

        // Random traffic with occasional clears
        for (int j = 0; j < 400; j++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_ch     = CHW'($urandom_range(0, CH - 1));
            in_data   = DW'($urandom);
            coef_a    = CW'($urandom);
            coef_b    = CW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_all   = ($urandom_range(0, 49) == 0);
            step();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/iir1_mc.md
Name: iir1_mc

Overview:
- Parametrised, multi-channel, time-multiplexed first-order IIR filter: y_c(n) = a*y_c(n-1) + b*x_c(n).
- Coefficients a and b are run-time inputs, not fixed constants.
- Per-channel state register file, valid/ready flow control on both sides, and a channel-clear sweep.
- Successor to the single-channel fixed-coefficient IIR stage in the DSP chain.

Parameters:
- DW, 8, input sample width (signed).
- CW, 4, coefficient width (signed).
- OW, 17, output/state width (signed).
- CH, 4, channel count (>=2).
- CHW, $clog2(CH), channel index width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- coef_a  in  CW  feedback coefficient a (signed), sampled with each accepted input.
- coef_b  in  CW  feed-forward coefficient b (signed), sampled with each accepted input.
- clr_all  in  1  pulse: zero all channel states.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_ch  in  CHW  channel of input sample.
- in_data  in  DW  signed input sample x.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts output.
- out_ch  out  CHW  channel of output.
- out_data  out  OW  signed output y.
- out_sat  out  1  output was clamped (only when IIR_SAT_EN is defined).

Behaviour:
- Reset (async, rst_n=0):
  - all CH state registers = 0; FSM = RUN; stage valids = 0.
  - out_valid=0, out_ch=0, out_data=0, out_sat=0.
- Pipeline: S1 (register x, ch, a, b; compute b*x) -> S2/output register (a*y_prev + bx, state write-back).
  - Latency: 2 cycles from accepting edge to out_valid=1.
  - Throughput: 1 sample/cycle.
- Flow control:
  - advance = !out_valid | out_ready.
  - in_ready = advance & (state==RUN).
  - Accept on in_valid & in_ready.
  - On stall, all stages hold; out_data/out_ch are stable while out_valid=1 & out_ready=0.
- Arithmetic:
  - Products are full precision: a*y is CW+OW bits; b*x is CW+DW bits.
  - Sum width ACC = CW+OW+1, sign-extended.
  - Result reduced to OW bits (see Optional Feature).
  - The reduced value is both the output and the new state (feedback uses the post-reduction value).
- Hazard: S1 reads y_prev for its channel. If S2 writes the same channel in the same advance, the forwarded new value is used. Back-to-back same-channel samples must equal the serial result.
- FSM:
  - RUN -> CLEAR when clr_all=1 (sampled at the edge; ignored while in CLEAR).
  - In CLEAR: in_ready=0; counter clr_idx counts 0..CH-1, zeroing state[clr_idx] each cycle; CLEAR -> RUN after clr_idx==CH-1.
  - Clear duration is exactly CH cycles.
  - In-flight samples still flow to the output during CLEAR, but their state write-back is suppressed. After CLEAR every state is 0.
- Coefficient changes take effect per sample (values captured at accept), with no pipeline flush.
- rst_n asserted mid-operation: in-flight samples are discarded, out_valid drops immediately, and CLEAR is aborted to RUN.

Optional Feature:
- Macro IIR_SAT_EN.
  - Defined: ACC result clamped to [-2^(OW-1), 2^(OW-1)-1]; out_sat=1 with the clamped output. The out_sat port exists only in this build.
  - Undefined: two's-complement wrap, keeping the low OW bits; no out_sat port.

Decomposition:
- Package iir_pkg: default widths, FSM state typedef (RUN, CLEAR), and a saturate/wrap function parameterised by ACC and OW.
- One sub-module, iir_mac: registered a*y + bx with the reduction step. Forwarding, state file and FSM live in the top.

Test Plan:
1. a=-2, b=3, ch0, x = 1,2,1,2… continuous, out_ready=1 -> out_data = 3,0,3,0…; first out_valid 2 cycles after first accept.
2. Channel independence: a=-2, b=3; interleave ch0 x=1 and ch1 x=2 every cycle -> ch0: 3,-3,9,-15…; ch1: 6,-6,18,-30… (checks same-cycle forwarding when the stream then switches to back-to-back same channel).
3. Saturation (IIR_SAT_EN): a=-2, b=3, ch0 x=1 constant, OW=17 -> y = 1-(-2)^n up to n=16 (-65535, out_sat=0); then 65535, -65536, 65535… with out_sat=1. Without the macro, the bench compares against the wrapped 17-bit model.
4. Backpressure: out_ready=0 for 3 cycles mid-stream -> in_ready=0, out_data/out_ch constant, no samples lost or duplicated; sequence matches test 1.
5. clr_all pulse with 2 samples in flight -> both still output; in_ready=0 for exactly CH=4 cycles; next ch0 x=1 gives y=3.
6. rst_n low for 1 cycle mid-stream -> out_valid=0 asynchronously; after release, ch0 x=2 with a=-2, b=3 gives y=6.
